co_x_router: RTL and testbench
==============================

// Module: co_x_router
// PURPOSE
//  Parametrised successor to the shared x operand register. Captures one W-bit operand
//  through a valid/ready input handshake and forwards it to exactly one of four execution
//  units: ALU, multiplier, divider or square-root. Each unit has its own valid/ready pair.
//  Sits between the keypad/operand-entry logic and the arithmetic units.
// PARAMETERS
//  W        8   operand width; must be even and >= 4
//  HW       W/2 width of the ALU/MUL operand (low half of x); derived, do not override
//  DIV_REV  1   1: divider gets x bit-reversed (to_div[i] = x[W-1-i]); 0: x unchanged
//  TO_CYC   16  SEND-state timeout in cycles, legal 2..255 (used only with CO_X_TIMEOUT_EN)
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  x_in       in   W    operand from entry logic
//  sel        in   2    destination, sampled with x_in: 00 ALU, 01 MUL, 10 DIV, 11 SQR
//  x_valid    in   1    x_in/sel valid
//  x_ready    out  1    router can accept an operand
//  to_alu     out  HW   x[HW-1:0] for the ALU
//  to_mul     out  HW   x[HW-1:0] for the multiplicand register
//  to_div     out  W    x for the dividend, bit-reversed when DIV_REV=1
//  to_sqr     out  W    x for the square-root unit
//  dst_valid  out  4    one-hot {SQR,DIV,MUL,ALU} offer valid
//  dst_ready  in   4    {SQR,DIV,MUL,ALU} unit accepts
//  busy       out  1    1 while in SEND
//  to_err     out  1    one-cycle pulse when an offer is dropped on timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all to_* = 0; dst_valid=0; to_err=0; x_ready=1
//   after reset deasserts; the latched operand and sel are cleared.
//  FSM, registered:
//   IDLE: x_ready=1, busy=0. When x_valid & x_ready at edge N: latch x_in and sel, go to SEND.
//   SEND: x_ready=0, busy=1. From cycle N+1: dst_valid[sel_q]=1 and the selected to_* holds
//     the latched value. When dst_valid[k] & dst_ready[k] at an edge: clear dst_valid and
//     the to_* output, go to IDLE. x_ready returns in the next cycle.
//  Latency: acceptance to offer is 1 cycle. Minimum period is 2 cycles per operand
//   (no accept in the same cycle as a hand-off).
//  Unselected to_* outputs are 0 at all times. The selected output is 0 in IDLE.
//  dst_valid is one-hot or zero, never more than one bit set.
//  x_in, sel and x_valid are ignored in SEND. Any sel change during SEND has no effect.
//  dst_ready bits other than dst_ready[sel_q] are ignored. A unit may hold ready high permanently.
//  Once dst_valid is asserted it stays asserted, and the data stays stable, until hand-off,
//   timeout, or reset.
//  Width: ALU and MUL take the truncated low half of x. No sign extension; x is unsigned.
//  Reset during SEND: the offer is aborted immediately and asynchronously. No hand-off is
//   counted.
// CONFIGURATION
//  CO_X_TIMEOUT_EN defined:
//   - An 8-bit counter clears on entry to SEND and increments on each SEND cycle without
//     a hand-off.
//   - If the count reaches TO_CYC-1 with no hand-off: drop the offer, clear dst_valid and
//     to_*, pulse to_err for 1 cycle, and go to IDLE.
//   - If the hand-off and the timeout fall in the same cycle, the hand-off wins and
//     to_err stays 0.
//  CO_X_TIMEOUT_EN undefined: no counter; SEND waits indefinitely; to_err is tied to 0.
// TESTING
//  1. W=8: reset low, then release -> all outputs 0, x_ready=1. Send x=0xA5, sel=00, with
//     dst_ready=0001 held -> next cycle to_alu=0x5, dst_valid=0001; one cycle later IDLE.
//  2. x=0xB4, sel=10, DIV_REV=1, dst_ready=0 for 5 cycles, then 0100 -> to_div=0x2D, stable
//     for 6 cycles; busy=1 and x_ready=0 throughout; clears after the hand-off.
//  3. While in SEND to MUL (x=0x37), drive x_valid=1, x_in=0xFF, sel=11 -> ignored; after the
//     MUL hand-off (to_mul=0x7) a new accept occurs and to_sqr=0xFF.
//  4. Drop rst_n for half a cycle while dst_valid=1000 -> dst_valid, to_sqr and busy are 0
//     immediately; after release, x_ready=1.
//  5. Macro on, TO_CYC=4, dst_ready=0 -> offer lasts 4 cycles, then to_err pulses once and
//     the block returns to IDLE. Repeat with ready asserted in cycle 4 -> hand-off occurs,
//     to_err stays 0.
//  6. Macro off -> dst_ready=0 for 300 cycles keeps dst_valid high; to_err never asserts.

Source files
------------

// File: rtl/co_x_router.sv
// co_x_router: latches one W-bit operand through a valid/ready handshake and
// offers it to exactly one of four execution units (ALU, MUL, DIV, SQR).
// Optional SEND-state timeout is enabled with the CO_X_TIMEOUT_EN macro.
module co_x_router #(
    parameter int W       = 8,
    parameter int HW      = W / 2,
    parameter int DIV_REV = 1,
    parameter int TO_CYC  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  x_in,
    input  logic [1:0]    sel,
    input  logic          x_valid,
    output logic          x_ready,
    output logic [HW-1:0] to_alu,
    output logic [HW-1:0] to_mul,
    output logic [W-1:0]  to_div,
    output logic [W-1:0]  to_sqr,
    output logic [3:0]    dst_valid,
    input  logic [3:0]    dst_ready,
    output logic          busy,
    output logic          to_err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MUL = 2'd1;
    localparam logic [1:0] SEL_DIV = 2'd2;
    localparam logic [1:0] SEL_SQR = 2'd3;

    state_t         state_reg, state_next;
    logic [W-1:0]   x_reg, x_next;
    logic [1:0]     sel_reg, sel_next;
    logic [W-1:0]   div_word;
    logic           in_send;
    logic           handoff;
    logic           timeout_hit;

    assign in_send = (state_reg == SEND);
    // Only the ready bit of the selected unit can complete the hand-off.
    assign handoff = in_send && dst_ready[sel_reg];

    // Divider operand: optionally bit-reversed copy of the latched word.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_div_bits
            if (DIV_REV != 0) begin : g_rev
                assign div_word[gi] = x_reg[W-1-gi];
            end else begin : g_fwd
                assign div_word[gi] = x_reg[gi];
            end
        end
    endgenerate

`ifdef CO_X_TIMEOUT_EN
    logic [7:0] count_reg, count_next;
    logic       err_reg, err_next;

    assign timeout_hit = in_send && !handoff && (count_reg == 8'(TO_CYC - 1));
    assign to_err      = err_reg;

    // Timeout counter: zero on entry to SEND, +1 per SEND cycle without hand-off.
    always_comb begin
        count_next = count_reg;
        err_next   = 1'b0;
        if (!in_send) begin
            count_next = 8'd0;
        end else if (timeout_hit) begin
            count_next = 8'd0;
            err_next   = 1'b1;
        end else if (!handoff) begin
            count_next = count_reg + 8'd1;
        end
    end

    // Timeout counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_err      = 1'b0;
`endif

    // State and latched operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            sel_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state logic: accept in IDLE, leave SEND on hand-off or timeout.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (x_valid) begin
                    x_next     = x_in;
                    sel_next   = sel;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (handoff || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: only the selected unit sees data, and only while in SEND.
    always_comb begin
        x_ready   = !in_send;
        busy      = in_send;
        dst_valid = 4'd0;
        to_alu    = '0;
        to_mul    = '0;
        to_div    = '0;
        to_sqr    = '0;
        if (in_send) begin
            case (sel_reg)
                SEL_ALU: begin
                    dst_valid = 4'b0001;
                    to_alu    = x_reg[HW-1:0];
                end
                SEL_MUL: begin
                    dst_valid = 4'b0010;
                    to_mul    = x_reg[HW-1:0];
                end
                SEL_DIV: begin
                    dst_valid = 4'b0100;
                    to_div    = div_word;
                end
                SEL_SQR: begin
                    dst_valid = 4'b1000;
                    to_sqr    = x_reg;
                end
                default: dst_valid = 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_co_x_router.sv
// Testbench for co_x_router: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_co_x_router;

    localparam int W      = 8;
    localparam int HW     = W / 2;
    localparam int TO_CYC = 4;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  x_in;
    logic [1:0]    sel;
    logic          x_valid;
    logic          x_ready;
    logic [HW-1:0] to_alu;
    logic [HW-1:0] to_mul;
    logic [W-1:0]  to_div;
    logic [W-1:0]  to_sqr;
    logic [3:0]    dst_valid;
    logic [3:0]    dst_ready;
    logic          busy;
    logic          to_err;

    int errors = 0;
    int checks = 0;

    // Reference model: one pending offer (or none) plus its age.
    bit       m_busy = 0;
    int       m_x    = 0;
    int       m_sel  = 0;
    int       m_age  = 0;
    bit       m_err  = 0;

    co_x_router #(.W(W), .DIV_REV(1), .TO_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .sel       (sel),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .to_alu    (to_alu),
        .to_mul    (to_mul),
        .to_div    (to_div),
        .to_sqr    (to_sqr),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .busy      (busy),
        .to_err    (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int reverse_bits(input int v);
        int r = 0;
        for (int i = 0; i < W; i++)
            if ((v >> i) & 1) r = r | (1 << (W - 1 - i));
        return r;
    endfunction

    // Compare every DUT output against what the model says is on offer.
    task automatic check_all();
        int e_alu = 0, e_mul = 0, e_div = 0, e_sqr = 0, e_dv = 0;
        if (m_busy) begin
            e_dv = 2 ** m_sel;
            if (m_sel == 0) e_alu = m_x % (2 ** HW);
            if (m_sel == 1) e_mul = m_x % (2 ** HW);
            if (m_sel == 2) e_div = reverse_bits(m_x);
            if (m_sel == 3) e_sqr = m_x;
        end
        check("x_ready",   32'(x_ready),   32'(!m_busy));
        check("busy",      32'(busy),      32'(m_busy));
        check("dst_valid", 32'(dst_valid), 32'(e_dv));
        check("to_alu",    32'(to_alu),    32'(e_alu));
        check("to_mul",    32'(to_mul),    32'(e_mul));
        check("to_div",    32'(to_div),    32'(e_div));
        check("to_sqr",    32'(to_sqr),    32'(e_sqr));
        check("to_err",    32'(to_err),    32'(m_err));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic xv, input logic [W-1:0] xi, input logic [1:0] s,
                        input logic [3:0] dr);
        x_valid   = xv;
        x_in      = xi;
        sel       = s;
        dst_ready = dr;
        @(posedge clk);
        if (!m_busy) begin
            m_err = 0;
            if (xv) begin
                m_busy = 1; m_x = int'(xi); m_sel = int'(s); m_age = 0;
                $display("TXN accept x=0x%02h sel=%0d", xi, s);
            end
        end else if (dr[m_sel]) begin
            m_busy = 0; m_err = 0;
            $display("TXN handoff x=0x%02h sel=%0d", m_x[7:0], m_sel);
        end else begin
`ifdef CO_X_TIMEOUT_EN
            if (m_age == TO_CYC - 1) begin
                m_busy = 0; m_err = 1;
                $display("TXN timeout x=0x%02h sel=%0d", m_x[7:0], m_sel);
            end else begin
                m_age++; m_err = 0;
            end
`else
            m_age++; m_err = 0;
`endif
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; x_valid = 1'b0; x_in = '0; sel = 2'd0; dst_ready = 4'd0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_x_ready", 32'(x_ready), 32'd1);
        check_all();

        // 1: ALU hand-off with ready held.
        step(1'b1, 8'hA5, 2'b00, 4'b0001);
        check("t1_alu", 32'(to_alu), 32'h5);
        check("t1_dv", 32'(dst_valid), 32'b0001);
        step(1'b0, 8'h00, 2'b00, 4'b0001);
        check("t1_idle", 32'(x_ready), 32'd1);

        // 2: DIV with bit reversal, ready delayed.
        step(1'b1, 8'hB4, 2'b10, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            check("t2_div", 32'(to_div), 32'h2D);
            check("t2_busy", 32'(busy), 32'd1);
            step(1'b0, 8'h00, 2'b00, 4'b0000);
        end
        check("t2_div_last", 32'(to_div), 32'h2D);
        step(1'b0, 8'h00, 2'b00, 4'b0100);
        check("t2_clear", 32'(to_div), 32'h0);

        // 3: new operand ignored during a MUL offer, then accepted.
        step(1'b1, 8'h37, 2'b01, 4'b0000);
        step(1'b1, 8'hFF, 2'b11, 4'b0000);
        check("t3_mul", 32'(to_mul), 32'h7);
        step(1'b1, 8'hFF, 2'b11, 4'b0010);
        step(1'b1, 8'hFF, 2'b11, 4'b0000);
        check("t3_sqr", 32'(to_sqr), 32'hFF);

        // 4: asynchronous reset while the SQR offer is pending.
        x_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t4_dv", 32'(dst_valid), 32'h0);
        check("t4_sqr", 32'(to_sqr), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        m_busy = 0; m_err = 0;
        #2 rst_n = 1'b1;
        #1;
        check("t4_ready", 32'(x_ready), 32'd1);
        @(negedge clk);
        check_all();

`ifdef CO_X_TIMEOUT_EN
        // 5: timeout after TO_CYC offer cycles, then hand-off in the last cycle.
        step(1'b1, 8'h5A, 2'b00, 4'b0000);
        for (int i = 0; i < TO_CYC - 1; i++) step(1'b0, 8'h00, 2'b00, 4'b0000);
        check("t5_dv_last", 32'(dst_valid), 32'b0001);
        step(1'b0, 8'h00, 2'b00, 4'b0000);
        check("t5_err", 32'(to_err), 32'd1);
        step(1'b0, 8'h00, 2'b00, 4'b0000);
        check("t5_err_once", 32'(to_err), 32'd0);
        step(1'b1, 8'h5A, 2'b00, 4'b0000);
        for (int i = 0; i < TO_CYC - 1; i++) step(1'b0, 8'h00, 2'b00, 4'b0000);
        step(1'b0, 8'h00, 2'b00, 4'b0001);
        check("t5_noerr", 32'(to_err), 32'd0);
        check("t5_idle", 32'(x_ready), 32'd1);
`else
        // 6: no timeout; offer held for 300 cycles.
        step(1'b1, 8'h81, 2'b10, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 2'b00, 4'b1011);
            check("t6_dv", 32'(dst_valid), 32'b0100);
        end
        step(1'b0, 8'h00, 2'b00, 4'b0100);
`endif

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] dr;
            dr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            step(1'($urandom), 8'($urandom), 2'($urandom), dr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
